// File: rtl/alu_resp.sv
// alu_resp: handshaked registered 8-bit ALU responder with a shift-add multiply sequencer.
module alu_resp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, prod;
  logic [WIDTH-1:0] mlier_q, mlier_d, res_q, res_d, alu_res;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, zero_q, zero_d, alu_c, accept;
  logic [WIDTH:0] sum, diff, shl;
  assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign out_valid = state_q == DONE;
  assign out_result = res_q;
  assign out_carry = carry_q;
  assign out_zero = zero_q;
  assign sum = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign shl = {1'b0, a} << b[2:0];
  assign prod = acc_q + (mlier_q[0] ? mcand_q : '0);
  always_comb begin
    alu_res = '0;
    alu_c = 1'b0;
    case (opcode)
      3'd0: {alu_c, alu_res} = sum;
      3'd1: {alu_c, alu_res} = diff;
      3'd2: alu_res = a & b;
      3'd3: alu_res = a | b;
      3'd4: alu_res = a ^ b;
      3'd5: alu_res = ~a;
      3'd6: {alu_c, alu_res} = shl;
      default: ;
    endcase
  end
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    mlier_d = mlier_q;
    cnt_d = cnt_q;
    res_d = res_q;
    carry_d = carry_q;
    zero_d = zero_q;
    if (accept && opcode == 3'd7) begin
      state_d = MUL;
      acc_d = '0;
      mcand_d = {{WIDTH{1'b0}}, a};
      mlier_d = b;
      cnt_d = '0;
    end else if (accept) begin
      state_d = DONE;
      res_d = alu_res;
      carry_d = alu_c;
      zero_d = alu_res == '0;
    end else if (state_q == MUL) begin
      acc_d = prod;
      mcand_d = mcand_q << 1;
      mlier_d = mlier_q >> 1;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = DONE;
        res_d = prod[WIDTH-1:0];
        carry_d = |prod[2*WIDTH-1:WIDTH];
        zero_d = prod[WIDTH-1:0] == '0;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      mcand_q <= '0;
      mlier_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      carry_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mlier_q <= mlier_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      carry_q <= carry_d;
      zero_q <= zero_d;
    end
  end
endmodule

// File: tb/tb_alu_resp.sv
// tb_alu_resp: vector table, hand sequences and a randomized scoreboard stream for alu_resp.
module tb_alu_resp;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_carry, out_zero;
  logic [7:0] a, b, out_result;
  logic [2:0] opcode;
  int checks = 0;
  int errors = 0;
  typedef struct packed {logic c; logic z; logic [7:0] r;} res_t;
  typedef struct packed {logic [7:0] a; logic [7:0] b; logic [2:0] op;} op_t;
  typedef struct packed {logic [7:0] a; logic [7:0] b; logic [2:0] op; logic [7:0] r; logic c; logic z;} vec_t;
  op_t ops[$];
  always #5 clk = ~clk;
  alu_resp #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .out_zero(out_zero)
  );
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask
  function automatic res_t model(input int x, input int y, input int op);
    int s, c;
    c = 0;
    case (op)
      0: begin s = x + y; c = s / 256; end
      1: begin s = x - y + 256; c = (x < y) ? 1 : 0; end
      2: s = x & y;
      3: s = x | y;
      4: s = x ^ y;
      5: s = 255 - x;
      6: begin s = x * (1 << (y % 8)); c = (s / 256) % 2; end
      default: begin s = x * y; c = (s > 255) ? 1 : 0; end
    endcase
    s = s % 256;
    return '{c[0], s == 0, s[7:0]};
  endfunction
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op,
                        output res_t res, output int lat, output int busy_ready);
    int n;
    @(negedge clk);
    a = x; b = y; opcode = op; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check("accept_timeout", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    busy_ready = 0;
    while (!out_valid && lat < 50) begin
      busy_ready |= int'(in_ready);
      @(posedge clk); #1;
      lat++;
    end
    res = '{out_carry, out_zero, out_result};
    @(posedge clk); #1;
  endtask
  task automatic run_stream(input bit rnd, input bit gaps);
    res_t exp[$];
    int idx, got, cyc, last;
    bit pend;
    idx = 0; got = 0; cyc = 0; last = -1; pend = 0;
    @(posedge clk); #1;
    while ((idx < ops.size() || got < ops.size()) && cyc < 5000) begin
      if (idx < ops.size()) begin
        a = ops[idx].a; b = ops[idx].b; opcode = ops[idx].op;
        if (!pend) pend = rnd ? ($urandom % 4 != 0) : 1'b1;
      end else pend = 0;
      in_valid = pend;
      out_ready = rnd ? 1'($urandom % 2) : 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp.size() == 0) check("stream_spurious", 32'd1, 32'd0);
        else check("stream_result", 32'({out_carry, out_zero, out_result}), 32'(exp.pop_front()));
        if (gaps && last >= 0) check("stream_gap", 32'(cyc - last), (ops[got].op == 3'd7) ? 32'd9 : 32'd1);
        last = cyc;
        got++;
      end
      if (in_valid && in_ready) begin
        exp.push_back(model(ops[idx].a, ops[idx].b, ops[idx].op));
        idx++;
        pend = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_accepted", 32'(idx), 32'(ops.size()));
    check("stream_responses", 32'(got), 32'(ops.size()));
  endtask
  initial begin
    vec_t vt[$];
    res_t res;
    int lat, busy, seen;
    vt = '{
      '{8'd200, 8'd100, 3'd0, 8'h2C, 1'b1, 1'b0},
      '{8'd5,   8'd7,   3'd1, 8'hFE, 1'b1, 1'b0},
      '{8'd9,   8'd9,   3'd1, 8'h00, 1'b0, 1'b1},
      '{8'd13,  8'd11,  3'd7, 8'h8F, 1'b0, 1'b0},
      '{8'd255, 8'd255, 3'd7, 8'h01, 1'b1, 1'b0},
      '{8'd16,  8'd16,  3'd7, 8'h00, 1'b1, 1'b1},
      '{8'd0,   8'd200, 3'd7, 8'h00, 1'b0, 1'b1},
      '{8'hC1,  8'h0A,  3'd6, 8'h04, 1'b1, 1'b0},
      '{8'h81,  8'h00,  3'd6, 8'h81, 1'b0, 1'b0},
      '{8'h03,  8'hFF,  3'd6, 8'h80, 1'b1, 1'b0},
      '{8'hFF,  8'h00,  3'd5, 8'h00, 1'b0, 1'b1},
      '{8'hF0,  8'h3C,  3'd2, 8'h30, 1'b0, 1'b0},
      '{8'hF0,  8'h3C,  3'd3, 8'hFC, 1'b0, 1'b0},
      '{8'hF0,  8'h3C,  3'd4, 8'hCC, 1'b0, 1'b0}
    };
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_outputs", 32'({out_carry, out_zero, out_result}), 32'd0);
    rst = 1'b0;
    foreach (vt[i]) begin
      run_op(vt[i].a, vt[i].b, vt[i].op, res, lat, busy);
      check($sformatf("vec%0d_result", i), 32'(res), 32'({vt[i].c, vt[i].z, vt[i].r}));
      check($sformatf("vec%0d_latency", i), 32'(lat), (vt[i].op == 3'd7) ? 32'd8 : 32'd0);
      check($sformatf("vec%0d_busy_ready", i), 32'(busy), 32'd0);
    end
    @(negedge clk);
    a = 8'd1; b = 8'd2; opcode = 3'd0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a = 8'd9; b = 8'd9; opcode = 3'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_result", 32'({out_carry, out_zero, out_result}), 32'h003);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_rise", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_swap_valid", 32'(out_valid), 32'd1);
    check("bp_swap_result", 32'({out_carry, out_zero, out_result}), 32'h100);
    @(posedge clk); #1;
    check("bp_retired", 32'(out_valid), 32'd0);
    ops = '{'{8'h5A, 8'h0F, 3'd4}, '{8'd250, 8'd10, 3'd0}, '{8'd3, 8'd4, 3'd1}, '{8'h11, 8'h22, 3'd3}};
    run_stream(1'b0, 1'b1);
    ops = '{'{8'h5A, 8'h0F, 3'd4}, '{8'd250, 8'd10, 3'd0}, '{8'd7, 8'd9, 3'd7}, '{8'd3, 8'd4, 3'd1}, '{8'h11, 8'h22, 3'd3}};
    run_stream(1'b0, 1'b1);
    run_op(8'd1, 8'd2, 3'd0, res, lat, busy);
    @(negedge clk);
    a = 8'd13; b = 8'd11; opcode = 3'd7; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_outputs", 32'({out_carry, out_zero, out_result}), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (12) begin @(negedge clk); seen |= int'(out_valid); end
    check("abort_no_response", 32'(seen), 32'd0);
    run_op(8'd3, 8'd4, 3'd0, res, lat, busy);
    check("abort_next_add", 32'(res), 32'h007);
    ops.delete();
    for (int i = 0; i < 300; i++) begin
      op_t o;
      o.a = ($urandom % 8 == 0) ? 8'hFF : 8'($urandom);
      o.b = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
      o.op = 3'($urandom);
      ops.push_back(o);
    end
    run_stream(1'b1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
